// File: rtl/debug_ctrl.sv
// -----------------------------------------------------------------------------
// debug_ctrl
// UART-driven debug controller for the pipelined CPU. Single-byte commands are
// read from the receive FIFO while idle. They can step or run the pipeline,
// read back registers, memory and the PC, move the debug pointers, reset or
// flush the program, and bootload a program image word by word.
//
// Ports
//   i_clk, i_reset         clock (rising edge), asynchronous active-low reset
//   i_rx_data/i_rx_empty   head byte and empty flag of the UART receive FIFO
//   o_rx_rd                pop strobe (combinational, the only unregistered out)
//   o_tx_data/o_tx_start   byte to transmit and its one-cycle start strobe
//   i_tx_busy              transmitter busy
//   o_enable_latch         pipeline latch enables
//   i_is_end               program has halted
//   o_debug_direcc_reg     register-file debug pointer, i_debug_read_reg its data
//   o_debug_direcc_mem     data-memory debug pointer, i_debug_read_mem its data
//   i_read_pc              current program counter
//   o_pc_reset             PC reset pulse
//   o_borrar_programa      program flush pulse
//   o_boot_write/addr/word boot-memory write port
//   o_programa_cargado     a complete program (ending in HALT_WORD) is loaded
// -----------------------------------------------------------------------------
module debug_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_LATCH   = 5,
  parameter int                REG_ADDR_W  = 5,
  parameter int                MEM_ADDR_W  = 7,
  parameter int                MEM_STRIDE  = 4,
  parameter int                BOOT_ADDR_W = 8,
  parameter logic [DATA_W-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_empty,
  output logic                   o_rx_rd,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic [NUM_LATCH-1:0]   o_enable_latch,
  input  logic                   i_is_end,
  output logic [REG_ADDR_W-1:0]  o_debug_direcc_reg,
  input  logic [DATA_W-1:0]      i_debug_read_reg,
  output logic [MEM_ADDR_W-1:0]  o_debug_direcc_mem,
  input  logic [DATA_W-1:0]      i_debug_read_mem,
  input  logic [DATA_W-1:0]      i_read_pc,
  output logic                   o_pc_reset,
  output logic                   o_borrar_programa,
  output logic                   o_boot_write,
  output logic [BOOT_ADDR_W-1:0] o_boot_addr,
  output logic [DATA_W-1:0]      o_boot_word,
  output logic                   o_programa_cargado
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]      ALL_BYTES = CNT_W'(NBYTES);
  localparam logic [MEM_ADDR_W-1:0] MEM_STEP  = MEM_ADDR_W'(MEM_STRIDE);

  localparam logic [7:0] CMD_STEP    = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN     = 8'h47;  // 'G'
  localparam logic [7:0] CMD_REG     = 8'h52;  // 'R'
  localparam logic [7:0] CMD_MEM     = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_PC      = 8'h50;  // 'P'
  localparam logic [7:0] CMD_REG_INC = 8'h54;  // 'T'
  localparam logic [7:0] CMD_REG_DEC = 8'h45;  // 'E'
  localparam logic [7:0] CMD_MEM_INC = 8'h2C;  // ','
  localparam logic [7:0] CMD_MEM_DEC = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_PC_RST  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_FLUSH   = 8'h46;  // 'F'
  localparam logic [7:0] CMD_BOOT    = 8'h42;  // 'B'

  typedef enum logic [2:0] {
    IDLE,
    STEP_ARG,
    STEP,
    RUN,
    SEND,
    BOOT,
    PULSE
  } state_t;

  state_t              state;
  logic [7:0]          step_cnt;
  logic [DATA_W-1:0]   send_word;
  logic [DATA_W-1:0]   boot_shift;
  logic [CNT_W-1:0]    byte_cnt;
  logic                send_wait;

  logic [REG_ADDR_W-1:0] reg_ptr_inc;
  logic [REG_ADDR_W-1:0] reg_ptr_dec;
  logic [MEM_ADDR_W-1:0] mem_ptr_inc;
  logic [MEM_ADDR_W-1:0] mem_ptr_dec;
  logic [DATA_W-1:0]     boot_word_next;

  // Only the states that consume FIFO bytes may pop, so bytes that arrive
  // during SEND, STEP or RUN wait in the FIFO until we are back in IDLE.
  // The pointer arithmetic wraps naturally at the pointer width, and the boot
  // word is assembled LSB-first by shifting each new byte in from the top.
  always_comb begin
    o_rx_rd = 1'b0;
    if (!i_rx_empty && (state == IDLE || state == STEP_ARG || state == BOOT))
      o_rx_rd = 1'b1;
    reg_ptr_inc    = o_debug_direcc_reg + 1'b1;
    reg_ptr_dec    = o_debug_direcc_reg - 1'b1;
    mem_ptr_inc    = o_debug_direcc_mem + MEM_STEP;
    mem_ptr_dec    = o_debug_direcc_mem - MEM_STEP;
    boot_word_next = (boot_shift >> 8) | (DATA_W'(i_rx_data) << (DATA_W - 8));
  end

  // Main controller. Strobes default low every cycle so each pulse lasts one
  // clock. The boot address advances in the cycle after a write, which keeps
  // o_boot_addr valid while o_boot_write is high. A flush in that same cycle
  // overrides the advance because it is assigned later.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state              <= IDLE;
      step_cnt           <= '0;
      send_word          <= '0;
      boot_shift         <= '0;
      byte_cnt           <= '0;
      send_wait          <= 1'b0;
      o_tx_data          <= '0;
      o_tx_start         <= 1'b0;
      o_enable_latch     <= '0;
      o_debug_direcc_reg <= REG_ADDR_W'(1);
      o_debug_direcc_mem <= MEM_STEP;
      o_pc_reset         <= 1'b0;
      o_borrar_programa  <= 1'b0;
      o_boot_write       <= 1'b0;
      o_boot_addr        <= '0;
      o_boot_word        <= '0;
      o_programa_cargado <= 1'b0;
    end else begin
      o_tx_start        <= 1'b0;
      o_pc_reset        <= 1'b0;
      o_borrar_programa <= 1'b0;
      o_boot_write      <= 1'b0;
      if (o_boot_write)
        o_boot_addr <= o_boot_addr + 1'b1;

      case (state)
        IDLE: begin
          if (!i_rx_empty) begin
            case (i_rx_data)
              CMD_STEP: state <= STEP_ARG;
              CMD_RUN: begin
                if (!i_is_end) begin
                  o_enable_latch <= '1;
                  state          <= RUN;
                end
              end
              CMD_REG: begin
                send_word <= i_debug_read_reg;
                byte_cnt  <= '0;
                send_wait <= 1'b0;
                state     <= SEND;
              end
              CMD_MEM: begin
                send_word <= i_debug_read_mem;
                byte_cnt  <= '0;
                send_wait <= 1'b0;
                state     <= SEND;
              end
              CMD_PC: begin
                send_word <= i_read_pc;
                byte_cnt  <= '0;
                send_wait <= 1'b0;
                state     <= SEND;
              end
              CMD_REG_INC: begin
                o_debug_direcc_reg <= reg_ptr_inc;
                send_word          <= DATA_W'(reg_ptr_inc);
                byte_cnt           <= '0;
                send_wait          <= 1'b0;
                state              <= SEND;
              end
              CMD_REG_DEC: begin
                o_debug_direcc_reg <= reg_ptr_dec;
                send_word          <= DATA_W'(reg_ptr_dec);
                byte_cnt           <= '0;
                send_wait          <= 1'b0;
                state              <= SEND;
              end
              CMD_MEM_INC: begin
                o_debug_direcc_mem <= mem_ptr_inc;
                send_word          <= DATA_W'(mem_ptr_inc);
                byte_cnt           <= '0;
                send_wait          <= 1'b0;
                state              <= SEND;
              end
              CMD_MEM_DEC: begin
                o_debug_direcc_mem <= mem_ptr_dec;
                send_word          <= DATA_W'(mem_ptr_dec);
                byte_cnt           <= '0;
                send_wait          <= 1'b0;
                state              <= SEND;
              end
              CMD_PC_RST: begin
                o_pc_reset <= 1'b1;
                state      <= PULSE;
              end
              CMD_FLUSH: begin
                o_pc_reset         <= 1'b1;
                o_borrar_programa  <= 1'b1;
                o_programa_cargado <= 1'b0;
                o_boot_addr        <= '0;
                state              <= PULSE;
              end
              CMD_BOOT: begin
                // A loaded program must be flushed before it can be reloaded.
                if (!o_programa_cargado) begin
                  byte_cnt   <= '0;
                  boot_shift <= '0;
                  state      <= BOOT;
                end
              end
              default: ;
            endcase
          end
        end

        STEP_ARG: begin
          // A step count of zero is treated as a single step.
          if (!i_rx_empty) begin
            step_cnt       <= (i_rx_data == 8'd0) ? 8'd1 : i_rx_data;
            o_enable_latch <= '1;
            state          <= STEP;
          end
        end

        STEP: begin
          if (i_is_end || step_cnt == 8'd1) begin
            o_enable_latch <= '0;
            state          <= IDLE;
          end else begin
            step_cnt <= step_cnt - 8'd1;
          end
        end

        RUN: begin
          if (i_is_end) begin
            o_enable_latch <= '0;
            state          <= IDLE;
          end
        end

        SEND: begin
          // send_wait covers the cycle after a start, giving the transmitter
          // time to raise busy before we look at it again.
          if (send_wait) begin
            send_wait <= 1'b0;
            if (byte_cnt == ALL_BYTES)
              state <= IDLE;
          end else if (!i_tx_busy) begin
            o_tx_data  <= send_word[7:0];
            o_tx_start <= 1'b1;
            send_word  <= send_word >> 8;
            byte_cnt   <= byte_cnt + 1'b1;
            send_wait  <= 1'b1;
          end
        end

        BOOT: begin
          if (!i_rx_empty) begin
            if (byte_cnt == LAST_BYTE) begin
              o_boot_word  <= boot_word_next;
              o_boot_write <= 1'b1;
              byte_cnt     <= '0;
              boot_shift   <= '0;
              if (boot_word_next == HALT_WORD) begin
                o_programa_cargado <= 1'b1;
                state              <= IDLE;
              end
            end else begin
              boot_shift <= boot_word_next;
              byte_cnt   <= byte_cnt + 1'b1;
            end
          end
        end

        PULSE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
